// File: rtl/csr_wport_arb.sv
// ---------------------------------------------------------------------------
// csr_wport_arb
//
// Arbitrates three CSR write requesters onto the single CSR file write port:
//   * trap sequencer  - multi-beat bursts, absolute priority, locks the port
//                       from its first beat until the beat flagged last
//   * EX stage        - single CSR-instruction writes, combinational ready
//   * hardware update - mip/counter writes, buffered in a 2-entry FIFO
//
// The winning beat is registered and presented on csr_we_o/csr_waddr_o/
// csr_wdata_o exactly one cycle after it transfers. Address and data are
// zero whenever csr_we_o is low.
//
// Configuration macro:
//   CSR_ARB_RR_EN  defined   -> EX and FIFO head share the port round-robin
//                  undefined -> EX always beats the FIFO head
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   trap_req_i/trap_last_i/trap_addr_i/trap_data_i, trap_gnt_o
//                                 trap burst requester
//   ex_valid_i/ex_addr_i/ex_data_i, ex_ready_o
//                                 EX-stage CSR write
//   hw_valid_i/hw_addr_i/hw_data_i, hw_ready_o
//                                 hardware update write (FIFO input)
//   csr_we_o/csr_waddr_o/csr_wdata_o
//                                 CSR file write port (registered)
//   stall_o                       EX write pending but not accepted
//   busy_o                        trap burst holds the port
// ---------------------------------------------------------------------------
module csr_wport_arb (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        trap_req_i,
    input  logic        trap_last_i,
    input  logic [11:0] trap_addr_i,
    input  logic [31:0] trap_data_i,
    output logic        trap_gnt_o,

    input  logic        ex_valid_i,
    input  logic [11:0] ex_addr_i,
    input  logic [31:0] ex_data_i,
    output logic        ex_ready_o,

    input  logic        hw_valid_i,
    input  logic [11:0] hw_addr_i,
    input  logic [31:0] hw_data_i,
    output logic        hw_ready_o,

    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o,

    output logic        stall_o,
    output logic        busy_o
);

    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_TRAP = 1'b1
    } state_e;

    state_e state_q;

    // -----------------------------------------------------------------------
    // Hardware-update FIFO (2 entries)
    // -----------------------------------------------------------------------
    logic [11:0] fifo_addr_q [2];
    logic [31:0] fifo_data_q [2];
    logic        fifo_rd_q;
    logic        fifo_wr_q;
    logic [1:0]  fifo_cnt_q;
    logic [1:0]  fifo_cnt_d;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;

    assign fifo_full  = (fifo_cnt_q == 2'd2);
    assign fifo_empty = (fifo_cnt_q == 2'd0);

    // Ready looks only at registered occupancy, so a full FIFO refuses a push
    // even in the cycle its head is being popped.
    assign hw_ready_o = ~rst_i & ~fifo_full;
    assign fifo_push  = hw_valid_i & hw_ready_o;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic arb_open;
    logic ex_win;
    logic hw_win;
    logic ex_gnt;

    // EX and FIFO only compete when no burst is locked and trap is quiet.
    assign arb_open = ~rst_i & (state_q == ST_ARB) & ~trap_req_i;

`ifdef CSR_ARB_RR_EN
    // rr_ex_q = 1 : EX has priority over the FIFO head on the next conflict.
    logic rr_ex_q;

    assign ex_win = fifo_empty | rr_ex_q;
    assign hw_win = ~ex_valid_i | ~rr_ex_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ex_q <= 1'b1;
        end else if (ex_gnt) begin
            rr_ex_q <= 1'b0;
        end else if (fifo_pop) begin
            rr_ex_q <= 1'b1;
        end
    end
`else
    assign ex_win = 1'b1;
    assign hw_win = ~ex_valid_i;
`endif

    // Trap wins in either state; in TRAP nobody else may be granted.
    assign trap_gnt_o = ~rst_i & trap_req_i;
    assign ex_gnt     = arb_open & ex_valid_i & ex_win;
    assign fifo_pop   = arb_open & ~fifo_empty & hw_win;
    assign ex_ready_o = ex_gnt;
    assign stall_o    = ex_valid_i & ~ex_ready_o;

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -----------------------------------------------------------------------
    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (fifo_push && !fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q + 2'd1;
        end else if (!fifo_push && fifo_pop) begin
            fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fifo_rd_q  <= 1'b0;
            fifo_wr_q  <= 1'b0;
            fifo_cnt_q <= 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_wr_q <= ~fifo_wr_q;
            end
            if (fifo_pop) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // Storage needs no reset: entries are only read when counted valid.
    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_addr_q[fifo_wr_q] <= hw_addr_i;
            fifo_data_q[fifo_wr_q] <= hw_data_i;
        end
    end

    // -----------------------------------------------------------------------
    // Trap lock FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_ARB;
        end else begin
            case (state_q)
                ST_ARB: begin
                    if (trap_gnt_o && !trap_last_i) begin
                        state_q <= ST_TRAP;
                    end
                end
                ST_TRAP: begin
                    if (trap_gnt_o && trap_last_i) begin
                        state_q <= ST_ARB;
                    end
                end
                default: state_q <= ST_ARB;
            endcase
        end
    end

    assign busy_o = (state_q == ST_TRAP);

    // -----------------------------------------------------------------------
    // Write-port mux and output register
    // -----------------------------------------------------------------------
    logic        beat_vld;
    logic [11:0] beat_addr;
    logic [31:0] beat_data;

    // Grants are mutually exclusive; the idle case drives zeros so the
    // registered address/data are zero whenever csr_we_o is low.
    always_comb begin
        beat_vld  = 1'b0;
        beat_addr = '0;
        beat_data = '0;
        if (trap_gnt_o) begin
            beat_vld  = 1'b1;
            beat_addr = trap_addr_i;
            beat_data = trap_data_i;
        end else if (ex_gnt) begin
            beat_vld  = 1'b1;
            beat_addr = ex_addr_i;
            beat_data = ex_data_i;
        end else if (fifo_pop) begin
            beat_vld  = 1'b1;
            beat_addr = fifo_addr_q[fifo_rd_q];
            beat_data = fifo_data_q[fifo_rd_q];
        end
    end

    logic        csr_we_q;
    logic [11:0] csr_waddr_q;
    logic [31:0] csr_wdata_q;

    // Async reset clears the in-flight beat immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            csr_we_q    <= 1'b0;
            csr_waddr_q <= '0;
            csr_wdata_q <= '0;
        end else begin
            csr_we_q    <= beat_vld;
            csr_waddr_q <= beat_addr;
            csr_wdata_q <= beat_data;
        end
    end

    assign csr_we_o    = csr_we_q;
    assign csr_waddr_o = csr_waddr_q;
    assign csr_wdata_o = csr_wdata_q;

endmodule

// File: tb/tb_csr_wport_arb.sv
module tb_csr_wport_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trap_req = 1'b0, trap_last = 1'b0;
    logic [11:0] trap_addr = '0;
    logic [31:0] trap_data = '0;
    logic        trap_gnt;
    logic        ex_valid = 1'b0;
    logic [11:0] ex_addr = '0;
    logic [31:0] ex_data = '0;
    logic        ex_ready;
    logic        hw_valid = 1'b0;
    logic [11:0] hw_addr = '0;
    logic [31:0] hw_data = '0;
    logic        hw_ready;
    logic        we;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        stall, busy;

    csr_wport_arb dut (
        .clk_i(clk), .rst_i(rst),
        .trap_req_i(trap_req), .trap_last_i(trap_last),
        .trap_addr_i(trap_addr), .trap_data_i(trap_data), .trap_gnt_o(trap_gnt),
        .ex_valid_i(ex_valid), .ex_addr_i(ex_addr), .ex_data_i(ex_data),
        .ex_ready_o(ex_ready),
        .hw_valid_i(hw_valid), .hw_addr_i(hw_addr), .hw_data_i(hw_data),
        .hw_ready_o(hw_ready),
        .csr_we_o(we), .csr_waddr_o(waddr), .csr_wdata_o(wdata),
        .stall_o(stall), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observation vector: {trap_gnt, ex_ready, hw_ready, stall, busy, we, waddr, wdata}
    typedef logic [49:0] obs_t;

    // Behavioural model: lock flag, FIFO as a queue, who is favoured next,
    // and the beat expected on the write port this cycle.
    logic        m_busy;
    logic [43:0] m_fifo[$];
    logic        m_fav_ex;
    logic        m_we;
    logic [11:0] m_addr;
    logic [31:0] m_data;
    logic [43:0] obs_log[$];

`ifdef CSR_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    function automatic void model_reset();
        m_busy   = 1'b0;
        m_fifo.delete();
        m_fav_ex = 1'b1;
        m_we     = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endfunction

    // Who the rules say gets the port this cycle.
    function automatic logic [2:0] who_wins();
        logic t, e, h, open;
        t = trap_req;
        open = !m_busy && !trap_req;
        if (RR) begin
            e = open && ex_valid && (m_fifo.size() == 0 || m_fav_ex);
            h = open && m_fifo.size() != 0 && (!ex_valid || !m_fav_ex);
        end else begin
            e = open && ex_valid;
            h = open && m_fifo.size() != 0 && !ex_valid;
        end
        return {t, e, h};
    endfunction

    function automatic obs_t model_exp();
        logic [2:0] g;
        if (rst) return {4'b0000 | {3'b000, ex_valid}, 46'h0};
        g = who_wins();
        return {g[2], g[1], (m_fifo.size() < 2), ex_valid & ~g[1], m_busy,
                m_we, m_addr, m_data};
    endfunction

    function automatic void model_next();
        logic [2:0] g;
        logic       room;
        if (rst) begin
            model_reset();
            return;
        end
        g    = who_wins();
        room = m_fifo.size() < 2;
        m_we = |g;
        {m_addr, m_data} = 44'h0;
        if (g[2]) begin
            {m_addr, m_data} = {trap_addr, trap_data};
            m_busy = !trap_last;
        end else if (g[1]) begin
            {m_addr, m_data} = {ex_addr, ex_data};
            m_fav_ex = 1'b0;
        end else if (g[0]) begin
            {m_addr, m_data} = m_fifo.pop_front();
            m_fav_ex = 1'b1;
        end
        if (hw_valid && room) m_fifo.push_back({hw_addr, hw_data});
    endfunction

    // One clock: sample away from the edge, predict, then advance.
    task automatic cyc(output obs_t o, output obs_t e);
        @(negedge clk);
        o = {trap_gnt, ex_ready, hw_ready, stall, busy, we, waddr, wdata};
        e = model_exp();
        if (o[44]) obs_log.push_back(o[43:0]);
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        trap_req = 1'b0; trap_last = 1'b0;
        ex_valid = 1'b0; hw_valid = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        model_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            trap_req = $urandom; ex_valid = $urandom; hw_valid = $urandom;
            trap_addr = $urandom; ex_addr = $urandom; hw_addr = $urandom;
            cyc(o, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset_state cyc%0d: got %h exp %h", i, o, e);
            end
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    task automatic test_trap_burst();
        obs_t o, e;
        logic [11:0] ta[4];
        logic [31:0] td[4];
        ta = '{12'h342, 12'h341, 12'h343, 12'h300};
        td = '{32'h8000_0007, 32'h0000_1040, 32'hDEAD_0001, 32'h0000_1800};
        obs_log.delete();
        ex_valid = 1'b1; ex_addr = 12'h305; ex_data = 32'h0000_2222;
        for (int i = 0; i < 4; i++) begin
            trap_req = 1'b1; trap_last = (i == 3);
            trap_addr = ta[i]; trap_data = td[i];
            cyc(o, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL trap_burst beat%0d: got %h exp %h", i, o, e);
            end
            checks++;
            if ({o[48], o[46]} !== 2'b01) begin
                errors++;
                $display("FAIL trap_ex_blocked beat%0d: ex_ready/stall got %b exp 01", i, {o[48], o[46]});
            end
        end
        trap_req = 1'b0; trap_last = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(o, e);
            if (o[48]) ex_valid = 1'b0;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL trap_tail cyc%0d: got %h exp %h", i, o, e);
            end
        end
        checks++;
        if (obs_log.size() != 5 ||
            obs_log[0] !== {12'h342, 32'h8000_0007} || obs_log[1] !== {ta[1], td[1]} ||
            obs_log[2] !== {ta[2], td[2]} || obs_log[3] !== {ta[3], td[3]} ||
            obs_log[4] !== {12'h305, 32'h0000_2222}) begin
            errors++;
            $display("FAIL trap_order: got %0d writes, first %h exp 342/80000007 then EX 305", obs_log.size(),
                     obs_log.size() ? obs_log[0] : 44'h0);
        end
    endtask

    task automatic test_trap_gap();
        obs_t o, e;
        obs_log.delete();
        for (int i = 0; i < 9; i++) begin
            trap_req  = (i < 2) || (i >= 5 && i < 7);
            trap_last = (i == 6);
            trap_addr = 12'h340 + 12'(i); trap_data = 32'hA000_0000 + i;
            if (i == 2) begin
                ex_valid = 1'b1; ex_addr = 12'h305; ex_data = 32'h55;
                hw_valid = 1'b1; hw_addr = 12'h344; hw_data = 32'h100;
            end
            if (i == 5) hw_valid = 1'b0;
            cyc(o, e);
            if (i >= 2 && i < 5 && o[47]) hw_data = hw_data + 1;
            if (o[48]) ex_valid = 1'b0;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL trap_gap cyc%0d: got %h exp %h", i, o, e);
            end
            if (i >= 2 && i < 5) begin
                checks++;
                if ({o[48], o[45], o[44] & (i > 2)} !== 3'b010) begin
                    errors++;
                    $display("FAIL gap_blocked cyc%0d: ex_ready/busy/we got %b exp 010", i, {o[48], o[45], o[44]});
                end
            end
            if (i == 4) begin
                checks++;
                if (o[47] !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_fifo_full: hw_ready got %b exp 0", o[47]);
                end
            end
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cyc(o, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL gap_drain cyc%0d: got %h exp %h", i, o, e);
            end
        end
        checks++;
        if (obs_log.size() != 7 || obs_log[0][43:32] !== 12'h340 || obs_log[1][43:32] !== 12'h341 ||
            obs_log[2][43:32] !== 12'h345 || obs_log[3][43:32] !== 12'h346) begin
            errors++;
            $display("FAIL gap_order: got %0d writes exp 7 with trap beats 340,341,345,346 first", obs_log.size());
        end
    endtask

    task automatic test_hw_push();
        obs_t o, e;
        logic [31:0] d;
        obs_log.delete();
        d = 32'h0000_0300;
        hw_valid = 1'b1; hw_addr = 12'h344; hw_data = d;
        for (int i = 0; i < 7; i++) begin
            cyc(o, e);
            if (o[47] && hw_valid) begin
                d = d + 1;
                hw_data = d;
                if (d == 32'h0000_0303) hw_valid = 1'b0;
            end
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL hw_push cyc%0d: got %h exp %h", i, o, e);
            end
        end
        checks++;
        if (obs_log.size() != 3 || obs_log[0] !== {12'h344, 32'h300} ||
            obs_log[1] !== {12'h344, 32'h301} || obs_log[2] !== {12'h344, 32'h302}) begin
            errors++;
            $display("FAIL hw_order: got %0d writes exp 3 (344:300,301,302)", obs_log.size());
        end
    endtask

    task automatic test_ex_vs_hw();
        obs_t o, e;
        logic [11:0] exp_a[4];
        obs_log.delete();
        ex_valid = 1'b1; ex_addr = 12'h305; ex_data = 32'h10;
        hw_valid = 1'b1; hw_addr = 12'h344; hw_data = 32'h20;
        for (int i = 0; i < 8; i++) begin
            cyc(o, e);
            if (o[48]) ex_data = ex_data + 1;
            if (o[47]) hw_data = hw_data + 1;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL ex_vs_hw cyc%0d: got %h exp %h", i, o, e);
            end
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cyc(o, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL ex_vs_hw_drain cyc%0d: got %h exp %h", i, o, e);
            end
        end
        if (RR) exp_a = '{12'h305, 12'h344, 12'h305, 12'h344};
        else    exp_a = '{12'h305, 12'h305, 12'h305, 12'h305};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_log.size() <= i || obs_log[i][43:32] !== exp_a[i]) begin
                errors++;
                $display("FAIL ex_vs_hw_order%0d: got %h exp %h", i,
                         obs_log.size() > i ? obs_log[i][43:32] : 12'hFFF, exp_a[i]);
            end
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(o, e);
            checks++;
            if (o !== e) begin
                errors++;
                bad++;
                if (bad < 10) $display("FAIL random cyc%0d: got %h exp %h", i, o, e);
            end
            if (!trap_req || o[49]) begin
                trap_req = ($urandom_range(0, 3) == 0); trap_last = $urandom_range(0, 2) == 0;
                trap_addr = $urandom; trap_data = $urandom;
            end
            if (!ex_valid || o[48]) begin
                ex_valid = $urandom; ex_addr = $urandom; ex_data = $urandom;
            end
            if (!hw_valid || o[47]) begin
                hw_valid = $urandom; hw_addr = $urandom; hw_data = $urandom;
            end
        end
        idle_inputs();
        trap_req = 1'b1; trap_last = 1'b1; trap_addr = 12'h300; trap_data = 32'h8;
        cyc(o, e);
        trap_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc(o, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random_drain cyc%0d: got %h exp %h", i, o, e);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        obs_t o, e;
        for (int i = 0; i < 2; i++) begin
            trap_req = 1'b1; trap_last = 1'b0;
            trap_addr = 12'h342 - 12'(i); trap_data = 32'hB0 + i;
            cyc(o, e);
        end
        idle_inputs();
        // Beat 2 is now on the write port; reset must kill it at once.
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({we, busy, waddr, wdata} !== 46'h0) begin
            errors++;
            $display("FAIL rst_async: we/busy/addr/data got %b/%b/%h/%h exp all 0", we, busy, waddr, wdata);
        end
        cyc(o, e);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL rst_hold: got %h exp %h", o, e);
        end
        rst = 1'b0;
        ex_valid = 1'b1; ex_addr = 12'h305; ex_data = 32'h0000_1000;
        cyc(o, e);
        checks++;
        if (o !== e || o[48] !== 1'b1) begin
            errors++;
            $display("FAIL rst_ex_grant: got %h exp %h", o, e);
        end
        ex_valid = 1'b0;
        cyc(o, e);
        checks++;
        if (o !== e || o[44:0] !== {1'b1, 12'h305, 32'h0000_1000}) begin
            errors++;
            $display("FAIL rst_ex_write: got %h exp we=1 305/00001000", o[44:0]);
        end
        cyc(o, e);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL rst_ex_after: got %h exp %h", o, e);
        end
    endtask

    initial begin
        test_reset();
        test_trap_burst();
        test_trap_gap();
        test_hw_push();
        test_ex_vs_hw();
        test_random();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
